seg7_scan_decoder: RTL and testbench
====================================

SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, SHALL set the consecutive identical cycles required before a digit is captured; legal range 2..255.
REQ-002 CLOCK_50  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be the synchronous, active-high reset.
REQ-004 SEG  input  7  SHALL be the active-low segment bus, bit0=a through bit6=g.
REQ-005 DIG  input  4  SHALL be the active-high one-hot digit enable; DIG[i] selects digit i, with digit 3 as the most significant.
REQ-006 out_ready  input  1  SHALL be the consumer ready signal.
REQ-007 VALUE  output  16  SHALL carry the decoded word, with nibble i taken from digit i.
REQ-008 ERR  output  4  SHALL carry per-digit unrecognised-pattern flags, aligned with VALUE nibbles.
REQ-009 out_valid  output  1  SHALL indicate that VALUE and ERR are valid.
REQ-010 LEDR  output  4  SHALL show the captured-digit mask of the frame in progress.

Function
REQ-011 Pattern table (SEG value -> nibble) SHALL be: 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 10->9, 08->A, 03->B, 46->C, 21->D, 06->E, 0E->F (hex).
REQ-012 Any other SEG value, including blank 7F, SHALL decode to nibble 0 with that digit's ERR bit set.
REQ-013 The block SHALL register {DIG,SEG} each cycle and keep a saturating stability counter, cleared whenever the current {DIG,SEG} differs from the previous cycle.
REQ-014 A capture SHALL occur exactly once per stable run, on the cycle the counter reaches STABLE_CYCLES-1, and only when DIG is one-hot.
REQ-015 DIG equal to zero or with more than one bit set SHALL clear the counter and never capture.
REQ-016 A capture SHALL write the decoded nibble and ERR bit into slot i and set mask bit i; recapturing a digit already in the mask SHALL overwrite the slot.
REQ-017 The FSM SHALL have two states, COLLECT and PRESENT.
REQ-018 COLLECT -> PRESENT SHALL occur on the cycle after the mask becomes 4'hF; out_valid SHALL rise in that same cycle, giving one-cycle latency from the final capture.
REQ-019 In PRESENT, VALUE, ERR and out_valid SHALL be held stable, and SEG/DIG captures SHALL be ignored, while the counter continues to track.
REQ-020 A handshake SHALL be out_valid & out_ready; on it the FSM SHALL return to COLLECT next cycle, clearing the mask and out_valid.
REQ-021 If out_ready is high on the cycle out_valid first rises, the handshake SHALL complete in that cycle.
REQ-022 VALUE and ERR SHALL retain the last presented word while in COLLECT; only out_valid qualifies them.
REQ-023 A capture attempted in the handshake cycle SHALL be dropped; the next frame starts with an empty mask.

Reset
REQ-024 reset SHALL force state COLLECT, VALUE=0, ERR=0, out_valid=0, mask/LEDR=0, stability counter=0 and history register=0, on the next edge.
REQ-025 reset asserted mid-frame or during PRESENT SHALL discard all partial captures and any unacknowledged word.
REQ-026 reset SHALL take priority over captures and handshakes in the same cycle.

Structure
REQ-027 A shared package seg7_pkg SHALL hold the 16 pattern constants, the BLANK (7F) constant and the FSM state enum.
REQ-028 A combinational sub-module seg7_pattern_decode (SEG in; nibble and err out) SHALL implement REQ-011 and REQ-012, and SHALL be instantiated once.
REQ-029 The counter width SHALL be 8 bits, saturating at 255.

Verification
REQ-030 Scenario: after reset, hold DIG=0001,SEG=30; DIG=0010,SEG=19; DIG=0100,SEG=02; DIG=1000,SEG=00 for 4 cycles each with out_ready=1 -> VALUE=16'h8643, ERR=0, out_valid high for one cycle.
REQ-031 Scenario: hold DIG=0001,SEG=40 for only 3 cycles, then change -> no capture, LEDR=0.
REQ-032 Scenario: complete a frame with digit 2 showing SEG=7F, holding out_ready=0 for 10 cycles -> ERR=4'b0100, nibble 2=0, and VALUE/out_valid stable for all 10 cycles.
REQ-033 Scenario: DIG=0011 held 20 cycles -> no capture; digit 0 captured twice (SEG=79, then SEG=0E) -> nibble 0 = F.
REQ-034 Scenario: assert reset after 3 digits are captured -> LEDR=0, out_valid=0; a fresh 4-digit frame is then required.
REQ-035 Scenario: back-to-back frames with out_ready tied high -> each word is presented exactly once, with no stale nibbles.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: segment pattern table, blank code and scan-decoder FSM states.
package seg7_pkg;
  localparam logic [6:0] BLANK = 7'h7F;
  localparam logic [6:0] PATTERNS [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  typedef enum logic {COLLECT, PRESENT} state_e;
endpackage

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode: maps an active-low segment pattern to its hex nibble, flagging unknown patterns.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] nib_o,
  output logic       err_o
);
  always_comb begin
    nib_o = '0;
    err_o = 1'b1;
    for (int k = 0; k < 16; k++)
      if (seg_i == PATTERNS[k]) begin
        nib_o = 4'(k);
        err_o = 1'b0;
      end
  end
endmodule

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: debounces a multiplexed 7-segment scan, assembles 4 digits into a word
// and presents it with a valid/ready handshake.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic [6:0]  SEG,
  input  logic [3:0]  DIG,
  input  logic        out_ready,
  output logic [15:0] VALUE,
  output logic [3:0]  ERR,
  output logic        out_valid,
  output logic [3:0]  LEDR
);
  state_e      state_q;
  logic [10:0] hist_q;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  mask_q, slot_err_q, err_q;
  logic [15:0] slot_q, value_q;
  logic        valid_q;
  logic [3:0]  nib;
  logic        nib_err, stable, cap;
  seg7_pattern_decode u_dec (.seg_i(SEG), .nib_o(nib), .err_o(nib_err));
  always_comb begin
    stable = ({DIG, SEG} == hist_q) && $onehot(DIG);
    cnt_d  = !stable ? '0 : (cnt_q == 8'hFF ? cnt_q : cnt_q + 8'd1);
    cap    = stable && (cnt_q == 8'(STABLE_CYCLES - 2));
  end
  // Captures only happen while collecting; a full mask hands the word over on the next edge.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q    <= COLLECT;
      hist_q     <= '0;
      cnt_q      <= '0;
      mask_q     <= '0;
      slot_q     <= '0;
      slot_err_q <= '0;
      value_q    <= '0;
      err_q      <= '0;
      valid_q    <= 1'b0;
    end else begin
      hist_q <= {DIG, SEG};
      cnt_q  <= cnt_d;
      if (state_q == COLLECT) begin
        if (mask_q == 4'hF) begin
          state_q <= PRESENT;
          value_q <= slot_q;
          err_q   <= slot_err_q;
          valid_q <= 1'b1;
        end else if (cap) begin
          for (int i = 0; i < 4; i++)
            if (DIG[i]) begin
              slot_q[4*i +: 4] <= nib;
              slot_err_q[i]    <= nib_err;
            end
          mask_q <= mask_q | DIG;
        end
      end else if (out_ready) begin
        state_q <= COLLECT;
        mask_q  <= '0;
        valid_q <= 1'b0;
      end
    end
  end
  assign VALUE     = value_q;
  assign ERR       = err_q;
  assign out_valid = valid_q;
  assign LEDR      = mask_q;
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb_seg7_scan_decoder: directed scenarios plus random scan traffic, checked each cycle
// against a run-length based reference model.
module tb_seg7_scan_decoder;
  import seg7_pkg::*;
  localparam int S = 4;
  localparam logic [6:0] TBL [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  localparam logic [3:0] DSET [8] = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd1, 4'd0, 4'd3, 4'hC};
  logic        CLOCK_50, reset, out_ready, out_valid;
  logic [6:0]  SEG;
  logic [3:0]  DIG, ERR, LEDR;
  logic [15:0] VALUE;
  int n_chk = 0, n_fail = 0;
  int          run_len;
  logic [10:0] prev_key;
  bit          pres;
  logic [3:0]  m_mask, m_slot_err, m_err;
  logic [3:0]  m_slots [4];
  logic [15:0] m_value;
  logic        m_valid;

  seg7_scan_decoder #(.STABLE_CYCLES(S)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .SEG(SEG), .DIG(DIG), .out_ready(out_ready),
    .VALUE(VALUE), .ERR(ERR), .out_valid(out_valid), .LEDR(LEDR)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  function automatic logic [4:0] decode(input logic [6:0] s);
    for (int i = 0; i < 16; i++) if (TBL[i] == s) return {1'b0, 4'(i)};
    return 5'h10;
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // A digit is captured on the S-th consecutive cycle of an identical one-hot scan value.
  task automatic step();
    logic [4:0] dec;
    int idx;
    @(posedge CLOCK_50);
    if (reset) begin
      prev_key = '0; run_len = 0; pres = 0; m_mask = '0; m_slot_err = '0;
      m_err = '0; m_value = '0; m_valid = 1'b0;
      for (int i = 0; i < 4; i++) m_slots[i] = '0;
    end else begin
      run_len  = ({DIG, SEG} == prev_key) ? run_len + 1 : 1;
      prev_key = {DIG, SEG};
      if (!pres) begin
        if (m_mask == 4'hF) begin
          pres = 1; m_valid = 1'b1; m_err = m_slot_err;
          m_value = {m_slots[3], m_slots[2], m_slots[1], m_slots[0]};
        end else if ($countones(DIG) == 1 && run_len == S) begin
          idx = 0;
          for (int i = 0; i < 4; i++) if (DIG[i]) idx = i;
          dec = decode(SEG);
          m_slots[idx] = dec[3:0]; m_slot_err[idx] = dec[4]; m_mask[idx] = 1'b1;
        end
      end else if (out_ready) begin
        pres = 0; m_mask = '0; m_valid = 1'b0;
      end
    end
    #1;
    chk("value", VALUE, m_value);
    chk("err", 16'(ERR), 16'(m_err));
    chk("valid", 16'(out_valid), 16'(m_valid));
    chk("ledr", 16'(LEDR), 16'(m_mask));
  endtask

  task automatic hold(input logic [3:0] d, input logic [6:0] s, input int n);
    DIG = d; SEG = s;
    repeat (n) step();
  endtask

  task automatic do_reset();
    reset = 1'b1; step(); reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; DIG = '0; SEG = BLANK; out_ready = 1'b0;
    step(); reset = 1'b0;
    chk("rst_value", VALUE, 16'h0);
    chk("rst_valid", 16'(out_valid), 16'h0);
    chk("rst_ledr", 16'(LEDR), 16'h0);
    // basic frame with ready already high
    out_ready = 1'b1;
    hold(4'b0001, 7'h30, 4); hold(4'b0010, 7'h19, 4);
    hold(4'b0100, 7'h02, 4); hold(4'b1000, 7'h00, 4);
    chk("s1_mask", 16'(LEDR), 16'hF);
    hold(4'b0000, BLANK, 1);
    chk("s1_value", VALUE, 16'h8643);
    chk("s1_err", 16'(ERR), 16'h0);
    chk("s1_valid", 16'(out_valid), 16'h1);
    hold(4'b0000, BLANK, 1);
    chk("s1_valid_drop", 16'(out_valid), 16'h0);
    // too-short hold
    hold(4'b0001, 7'h40, 3); hold(4'b0000, BLANK, 2);
    chk("s2_ledr", 16'(LEDR), 16'h0);
    // blank digit, stalled consumer
    out_ready = 1'b0;
    hold(4'b0001, 7'h40, 4); hold(4'b0010, 7'h79, 4);
    hold(4'b0100, BLANK, 4); hold(4'b1000, 7'h24, 4);
    hold(4'b0000, BLANK, 1);
    chk("s3_err", 16'(ERR), 16'h4);
    chk("s3_value", VALUE, 16'h2010);
    for (int i = 0; i < 10; i++) begin
      hold(DSET[$urandom_range(0, 3)], TBL[$urandom_range(0, 15)], 1);
      chk("s3_hold_value", VALUE, 16'h2010);
      chk("s3_hold_valid", 16'(out_valid), 16'h1);
    end
    out_ready = 1'b1;
    hold(4'b0000, BLANK, 1);
    chk("s3_release", 16'(out_valid), 16'h0);
    // multi-hot digit enable, recapture of digit 0
    hold(4'b0011, 7'h40, 20);
    chk("s4_multi", 16'(LEDR), 16'h0);
    hold(4'b0001, 7'h79, 4);
    chk("s4_first", 16'(LEDR), 16'h1);
    hold(4'b0001, 7'h0E, 4); hold(4'b0010, 7'h40, 4);
    hold(4'b0100, 7'h40, 4); hold(4'b1000, 7'h40, 4);
    hold(4'b0000, BLANK, 1);
    chk("s4_value", VALUE, 16'h000F);
    chk("s4_valid", 16'(out_valid), 16'h1);
    hold(4'b0000, BLANK, 1);
    // reset mid-frame
    out_ready = 1'b0;
    hold(4'b0001, 7'h79, 4); hold(4'b0010, 7'h24, 4); hold(4'b0100, 7'h30, 4);
    chk("s5_partial", 16'(LEDR), 16'h7);
    do_reset();
    chk("s5_ledr", 16'(LEDR), 16'h0);
    chk("s5_valid", 16'(out_valid), 16'h0);
    chk("s5_value", VALUE, 16'h0);
    hold(4'b1000, 7'h19, 4); hold(4'b0000, BLANK, 2);
    chk("s5_one", 16'(LEDR), 16'h8);
    chk("s5_not_valid", 16'(out_valid), 16'h0);
    out_ready = 1'b1;
    hold(4'b0001, 7'h12, 4); hold(4'b0010, 7'h02, 4); hold(4'b0100, 7'h78, 4);
    hold(4'b0000, BLANK, 1);
    chk("s5_value2", VALUE, 16'h4765);
    // back-to-back frames with ready tied high
    hold(4'b0001, 7'h79, 4); hold(4'b0010, 7'h24, 4);
    hold(4'b0100, 7'h30, 4); hold(4'b1000, 7'h19, 4);
    hold(4'b0000, BLANK, 1);
    chk("s6_a", VALUE, 16'h4321);
    hold(4'b0001, 7'h12, 4); hold(4'b0010, 7'h02, 4);
    hold(4'b0100, 7'h78, 4); hold(4'b1000, 7'h00, 4);
    hold(4'b0000, BLANK, 1);
    chk("s6_b", VALUE, 16'h8765);
    // random scan traffic
    for (int i = 0; i < 600; i++) begin
      out_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 59) == 0) do_reset();
      hold(DSET[$urandom_range(0, 7)],
           ($urandom_range(0, 3) != 0) ? TBL[$urandom_range(0, 15)] : 7'($urandom),
           $urandom_range(1, 6));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
